// File: rtl/vedic8_seq_mult_if.sv
// Operand/result handshake bundle for the sequential Vedic multiplier.
// The slave side is the multiplier; the master side is source plus sink.
interface vedic8_seq_mult_if #(
  parameter int N = 4
);
  logic [2*N-1:0] a;
  logic [2*N-1:0] b;
  logic           in_valid;
  logic           in_ready;
  logic [4*N-1:0] p;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, p, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, p, out_valid
  );
endinterface

// File: rtl/vedic8_seq_mult.sv
// 2N x 2N unsigned multiplier: one N x N Urdhva Tiryagbhyam core
// reused over four cycles, partial products accumulated into 4N bits.
module vedic8_seq_mult #(
  parameter int N = 4
) (
  input logic             clk,
  input logic             rst_n,
  vedic8_seq_mult_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int PW = 4 * N;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      step;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   p_q;
  logic            out_valid_q;

  logic [N-1:0]    x;
  logic [N-1:0]    y;
  logic [W-1:0]    pp;
  logic [W-1:0]    col;
  logic [W-1:0]    carry;
  logic [PW-1:0]   ext;
  logic [PW-1:0]   ext_s;
  logic [PW-1:0]   sum;

  // step[0] picks the a half, step[1] the b half
  assign x = step[0] ? a_q[W-1:N] : a_q[N-1:0];
  assign y = step[1] ? b_q[W-1:N] : b_q[N-1:0];

  // Vertical/crosswise columns, each carry rippling into the next
  always_comb begin
    pp    = '0;
    col   = '0;
    carry = '0;
    for (int k = 0; k < W - 1; k++) begin
      col = carry;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i + j == k) begin
            col = col + {{(W-1){1'b0}}, x[i] & y[j]};
          end
        end
      end
      pp[k] = col[0];
      carry = col >> 1;
    end
    pp[W-1] = carry[0];
  end

  always_comb begin
    ext   = {{W{1'b0}}, pp};
    ext_s = ext;
    unique case (step)
      2'd0: ext_s = ext;
      2'd1: ext_s = ext << N;
      2'd2: ext_s = ext << N;
      2'd3: ext_s = ext << W;
      default: ext_s = ext;
    endcase
    sum = acc + ext_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      acc         <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc   <= '0;
            step  <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          acc  <= sum;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            p_q         <= sum;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;
endmodule
